// File: rtl/csr_if_layer_engine_pkg.sv
// snn_layer_pkg: shared definitions for the CSR integrate-and-fire layer engine.
//   state_e    : engine sequencing states
//   RESET_SUB  : membrane voltage minus threshold after a spike
//   RESET_ZERO : membrane voltage cleared after a spike
//   saturate() : clamp a wide signed value into a w-bit signed range
package snn_layer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CLEAR    = 4'd1,
    ST_OFF_REQ  = 4'd2,
    ST_OFF_WAIT = 4'd3,
    ST_MAC      = 4'd4,
    ST_DRAIN    = 4'd5,
    ST_STORE    = 4'd6,
    ST_ACC      = 4'd7,
    ST_DONE     = 4'd8
  } state_e;

  localparam int RESET_SUB  = 0;
  localparam int RESET_ZERO = 1;

  // Callers size-cast the result down to w bits; the upper bits are plain sign extension.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                   input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] y;
    hi = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) begin
      y = hi;
    end else if (x < lo) begin
      y = lo;
    end else begin
      y = x;
    end
    return y;
  endfunction

endpackage

// File: rtl/csr_if_layer_engine_fifo.sv
// aer_fifo: synchronous FIFO holding AER spike events.
//   clk, rst_n    : clock, synchronous active-low reset (empties the FIFO)
//   push, wdata   : write request and data (push while full is accepted only with a pop)
//   pop           : remove head entry (ignored when empty)
//   rdata         : head entry, forced to zero while empty
//   full, empty   : occupancy flags
module aer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wptr_r;
  logic [AW:0]      rptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Occupancy flags from wrap-bit pointers, head data and accepted transfers.
  always_comb begin
    empty     = (wptr_r == rptr_r);
    full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    if (empty) begin
      rdata = {WIDTH{1'b0}};
    end else begin
      rdata = mem_r[rptr_r[AW-1:0]];
    end
  end

  // Pointer update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_r <= {(AW+1){1'b0}};
      rptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wptr_r <= wptr_r + (AW+1)'(1);
      if (do_pop_s)  rptr_r <= rptr_r + (AW+1)'(1);
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wptr_r[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/csr_if_layer_engine.sv
// csr_if_layer_engine: per frame, builds each neuron's input current from CSR-packed
// sparse weights, then runs T_STEPS integrate-and-fire steps and emits AER spikes.
//   start/busy/done                  : frame handshake
//   off_addr/off_count               : per-neuron nonzero count memory (1-cycle read)
//   csr_addr/csr_weight/csr_index    : CSR weight memory (1-cycle read)
//   act_addr/act_data                : activation memory, addressed by csr_index
//   spike_valid/ready/aer/step       : AER event stream from the output FIFO
module csr_if_layer_engine
  import snn_layer_pkg::*;
#(
  parameter int N_NEURONS  = 40,
  parameter int IN_ADDR_W  = 10,
  parameter int ACT_W      = 8,
  parameter int W_W        = 8,
  parameter int V_W        = 16,
  parameter int CSR_ADDR_W = 14,
  parameter int CNT_W      = 10,
  parameter int T_STEPS    = 4,
  parameter logic signed [V_W-1:0] THRESHOLD = 16'sd1024,
  parameter int RESET_MODE = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(N_NEURONS)-1:0]  off_addr,
  input  logic [CNT_W-1:0]              off_count,
  output logic [CSR_ADDR_W-1:0]         csr_addr,
  input  logic [W_W-1:0]                csr_weight,
  input  logic [IN_ADDR_W-1:0]          csr_index,
  output logic [IN_ADDR_W-1:0]          act_addr,
  input  logic [ACT_W-1:0]              act_data,
  output logic                          spike_valid,
  input  logic                          spike_ready,
  output logic [$clog2(N_NEURONS)-1:0]  spike_aer,
  output logic [$clog2(T_STEPS):0]      spike_step
);

  localparam int NW     = $clog2(N_NEURONS);
  localparam int SW     = $clog2(T_STEPS) + 1;
  localparam int ACC_W  = V_W + 8;
  localparam int PROD_W = W_W + ACT_W + 1;

  state_e                  state_r, state_next_s;
  logic [NW-1:0]           n_r;
  logic [SW-1:0]           s_r;
  logic [CNT_W-1:0]        rem_r;
  logic [CSR_ADDR_W-1:0]   ptr_r;
  logic                    drain_r, fin_r, v1_r, v2_r;
  logic signed [W_W-1:0]   w_d_r;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [V_W-1:0]   i_mem_r [N_NEURONS];
  logic signed [V_W-1:0]   v_mem_r [N_NEURONS];
  logic signed [V_W-1:0]   vnew_s, vafter_s;
  logic                    fire_s, acc_live_s, push_s, pop_s, adv_s;
  logic                    last_n_s, last_s_s;
  logic                    full_s, empty_s;
  logic [NW+SW-1:0]        head_s;
  logic                    busy_s, done_s, busy_r, done_r;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:     state_next_s = start ? ST_CLEAR : ST_IDLE;
      ST_CLEAR:    state_next_s = last_n_s ? ST_OFF_REQ : ST_CLEAR;
      ST_OFF_REQ:  state_next_s = ST_OFF_WAIT;
      ST_OFF_WAIT: state_next_s = (off_count == {CNT_W{1'b0}}) ? ST_STORE : ST_MAC;
      ST_MAC:      state_next_s = (rem_r == CNT_W'(1)) ? ST_DRAIN : ST_MAC;
      ST_DRAIN:    state_next_s = drain_r ? ST_STORE : ST_DRAIN;
      ST_STORE:    state_next_s = last_n_s ? ST_ACC : ST_OFF_REQ;
      // fin_r marks the last step done; hold until every spike has left the FIFO.
      ST_ACC:      state_next_s = (fin_r && empty_s) ? ST_DONE : ST_ACC;
      ST_DONE:     state_next_s = ST_IDLE;
      default:     state_next_s = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state, so busy/done can be registered.
  always_comb begin
    busy_s = 1'b1;
    done_s = 1'b0;
    case (state_next_s)
      ST_IDLE: busy_s = 1'b0;
      ST_DONE: begin
        busy_s = 1'b0;
        done_s = 1'b1;
      end
      default: busy_s = 1'b1;
    endcase
  end

  // Registered frame handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  // Integrate-and-fire datapath and FIFO handshake for the neuron under n_r.
  always_comb begin
    last_n_s   = (n_r == NW'(N_NEURONS - 1));
    last_s_s   = (s_r == SW'(T_STEPS - 1));
    vnew_s     = V_W'(saturate(64'(v_mem_r[n_r]) + 64'(i_mem_r[n_r]), V_W));
    fire_s     = (vnew_s >= THRESHOLD);
    if (!fire_s) begin
      vafter_s = vnew_s;
    end else if (RESET_MODE == RESET_ZERO) begin
      vafter_s = {V_W{1'b0}};
    end else begin
      vafter_s = vnew_s - THRESHOLD;
    end
    acc_live_s = (state_r == ST_ACC) && !fin_r;
    pop_s      = spike_ready && !empty_s;
    // A full FIFO still takes a spike when the head leaves in the same cycle.
    push_s     = acc_live_s && fire_s && (!full_s || pop_s);
    adv_s      = acc_live_s && (!fire_s || !full_s || pop_s);
    prod_s     = PROD_W'(w_d_r) * PROD_W'($signed({1'b0, act_data}));
  end

  // Sequencing counters and the CSR pointer (never reset between neurons).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_r     <= {NW{1'b0}};
      s_r     <= {SW{1'b0}};
      rem_r   <= {CNT_W{1'b0}};
      ptr_r   <= {CSR_ADDR_W{1'b0}};
      drain_r <= 1'b0;
      fin_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          n_r   <= {NW{1'b0}};
          s_r   <= {SW{1'b0}};
          fin_r <= 1'b0;
        end
        ST_CLEAR: begin
          ptr_r <= {CSR_ADDR_W{1'b0}};
          n_r   <= last_n_s ? {NW{1'b0}} : n_r + NW'(1);
        end
        ST_OFF_WAIT: rem_r <= off_count;
        ST_MAC: begin
          ptr_r <= ptr_r + CSR_ADDR_W'(1);
          rem_r <= rem_r - CNT_W'(1);
        end
        ST_DRAIN: drain_r <= !drain_r;
        ST_STORE: n_r <= last_n_s ? {NW{1'b0}} : n_r + NW'(1);
        ST_ACC: begin
          if (adv_s) begin
            if (last_n_s) begin
              n_r <= {NW{1'b0}};
              if (last_s_s) fin_r <= 1'b1;
              else          s_r   <= s_r + SW'(1);
            end else begin
              n_r <= n_r + NW'(1);
            end
          end
        end
        default: n_r <= n_r;
      endcase
    end
  end

  // MAC pipe: v1 = CSR data valid, v2 = activation valid; weight delayed to meet act_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_r  <= 1'b0;
      v2_r  <= 1'b0;
      w_d_r <= {W_W{1'b0}};
      acc_r <= {ACC_W{1'b0}};
    end else begin
      v1_r  <= (state_r == ST_MAC);
      v2_r  <= v1_r;
      w_d_r <= csr_weight;
      if (state_r == ST_OFF_REQ) acc_r <= {ACC_W{1'b0}};
      else if (v2_r)             acc_r <= acc_r + ACC_W'(prod_s);
    end
  end

  // Current and voltage arrays.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      case (state_r)
        ST_CLEAR: begin
          i_mem_r[n_r] <= {V_W{1'b0}};
          v_mem_r[n_r] <= {V_W{1'b0}};
        end
        ST_STORE: i_mem_r[n_r] <= V_W'(saturate(64'(acc_r), V_W));
        ST_ACC:   if (adv_s) v_mem_r[n_r] <= vafter_s;
        default:  i_mem_r[n_r] <= i_mem_r[n_r];
      endcase
    end
  end

  aer_fifo #(.WIDTH(NW + SW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({n_r, s_r}),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  assign off_addr    = n_r;
  assign csr_addr    = ptr_r;
  assign act_addr    = csr_index;
  assign busy        = busy_r;
  assign done        = done_r;
  assign spike_valid = !empty_s;
  assign spike_aer   = head_s[NW+SW-1:SW];
  assign spike_step  = head_s[SW-1:0];

endmodule

// File: tb/tb_csr_if_layer_engine.sv
// Scoreboard bench: two engines (subtract and zero reset) share external memory models.
module tb_csr_if_layer_engine;
  localparam int N = 4;
  localparam int T = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start0, start1, ready0, ready1;
  logic busy0, busy1, done0, done1, sv0, sv1;
  logic [1:0] off_addr0, off_addr1, aer0, aer1;
  logic [2:0] step0, step1;
  logic [9:0] off_count0, off_count1, csr_index0, csr_index1, act_addr0, act_addr1;
  logic [13:0] csr_addr0, csr_addr1;
  logic [7:0] csr_weight0, csr_weight1, act_data0, act_data1;

  logic [9:0] off_mem [N];
  logic [7:0] w_mem   [64];
  logic [9:0] idx_mem [64];
  logic [7:0] act_mem [64];

  logic [4:0] exp0[$];
  logic [4:0] exp1[$];
  int tests = 0;
  int fails = 0;
  int done_cnt0 = 0;

  csr_if_layer_engine #(.N_NEURONS(N), .T_STEPS(T), .THRESHOLD(16'sd100),
                        .RESET_MODE(0), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
    .off_addr(off_addr0), .off_count(off_count0), .csr_addr(csr_addr0),
    .csr_weight(csr_weight0), .csr_index(csr_index0), .act_addr(act_addr0),
    .act_data(act_data0), .spike_valid(sv0), .spike_ready(ready0),
    .spike_aer(aer0), .spike_step(step0));

  csr_if_layer_engine #(.N_NEURONS(N), .T_STEPS(T), .THRESHOLD(16'sd100),
                        .RESET_MODE(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .off_addr(off_addr1), .off_count(off_count1), .csr_addr(csr_addr1),
    .csr_weight(csr_weight1), .csr_index(csr_index1), .act_addr(act_addr1),
    .act_data(act_data1), .spike_valid(sv1), .spike_ready(ready1),
    .spike_aer(aer1), .spike_step(step1));

  // Registered-read memory models, one read port set per engine.
  always @(posedge clk) begin
    off_count0  <= off_mem[off_addr0];
    csr_weight0 <= w_mem[csr_addr0[5:0]];
    csr_index0  <= idx_mem[csr_addr0[5:0]];
    act_data0   <= act_mem[act_addr0[5:0]];
    off_count1  <= off_mem[off_addr1];
    csr_weight1 <= w_mem[csr_addr1[5:0]];
    csr_index1  <= idx_mem[csr_addr1[5:0]];
    act_data1   <= act_mem[act_addr1[5:0]];
  end

  // Monitors: each accepted event is popped from the matching expectation queue.
  always @(negedge clk) begin
    if (rst_n && sv0 && ready0) begin
      tests++;
      if (exp0.size() == 0) begin
        fails++;
        $display("FAIL ev0_unexpected: got n=%0d s=%0d required no event", aer0, step0);
      end else begin
        logic [4:0] e;
        e = exp0.pop_front();
        if ({aer0, step0} !== e) begin
          fails++;
          $display("FAIL ev0: got n=%0d s=%0d required n=%0d s=%0d", aer0, step0, e[4:3], e[2:0]);
        end
      end
    end
    if (rst_n && sv1 && ready1) begin
      tests++;
      if (exp1.size() == 0) begin
        fails++;
        $display("FAIL ev1_unexpected: got n=%0d s=%0d required no event", aer1, step1);
      end else begin
        logic [4:0] e;
        e = exp1.pop_front();
        if ({aer1, step1} !== e) begin
          fails++;
          $display("FAIL ev1: got n=%0d s=%0d required n=%0d s=%0d", aer1, step1, e[4:3], e[2:0]);
        end
      end
    end
    if (done0) done_cnt0++;
  end

  function automatic logic [4:0] ev(input int n, input int s);
    return {2'(n), 3'(s)};
  endfunction

  task automatic check(input string name, input longint got, input longint req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < N; i++) off_mem[i] = 10'd0;
    for (int i = 0; i < 64; i++) begin
      w_mem[i] = 8'd0; idx_mem[i] = 10'd0; act_mem[i] = 8'd0;
    end
  endtask

  // Neuron 0: weights {2,-1,4} x activations 10 -> I=50.
  task automatic load_a();
    clear_mem();
    off_mem[0] = 10'd3;
    w_mem[0] = 8'd2;   idx_mem[0] = 10'd5;
    w_mem[1] = 8'hFF;  idx_mem[1] = 10'd6;
    w_mem[2] = 8'd4;   idx_mem[2] = 10'd7;
    act_mem[5] = 8'd10; act_mem[6] = 8'd10; act_mem[7] = 8'd10;
  endtask

  task automatic pulse_start(input bit s0, input bit s1);
    @(negedge clk); start0 = s0; start1 = s1;
    @(negedge clk); start0 = 1'b0; start1 = 1'b0;
  endtask

  // Called at the first negedge after the start edge; cyc0 counts edges from that edge.
  task automatic wait_frame(input bit both, output int cyc0);
    bit seen0, seen1;
    int cyc;
    seen0 = 1'b0; seen1 = !both; cyc = 1; cyc0 = -1;
    while (!(seen0 && seen1) && cyc < 3000) begin
      if (done0 && !seen0) begin seen0 = 1'b1; cyc0 = cyc; end
      if (done1) seen1 = 1'b1;
      if (!(seen0 && seen1)) begin @(negedge clk); cyc++; end
    end
    tests++;
    if (!(seen0 && seen1)) begin
      fails++;
      $display("FAIL frame_timeout: got no done after %0d cycles required done", cyc);
    end
  endtask

  initial begin
    int cyc;
    int d;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; ready0 = 1'b1; ready1 = 1'b1;
    clear_mem();
    repeat (3) @(negedge clk);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_valid", sv0, 0);
    check("rst_aer", aer0, 0);
    check("rst_step", step0, 0);
    check("rst_off_addr", off_addr0, 0);
    check("rst_csr_addr", csr_addr0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame: I[0]=50, threshold 100 -> spikes at steps 1 and 3.
    load_a();
    exp0.push_back(ev(0, 1)); exp0.push_back(ev(0, 3));
    pulse_start(1'b1, 1'b0);
    check("a_busy", busy0, 1);
    wait_frame(1'b0, cyc);
    repeat (3) @(negedge clk);
    check("a_drained", exp0.size(), 0);

    // All counts zero: no spikes, fixed latency.
    clear_mem();
    pulse_start(1'b1, 1'b0);
    wait_frame(1'b0, cyc);
    check("zero_latency", cyc, 4 * N + T * N + 2);
    check("zero_busy_at_done", busy0, 0);
    check("zero_valid", sv0, 0);
    @(negedge clk);
    check("zero_done_pulse", done0, 0);

    // Saturation: I[1]=2*127*255 -> 32767; I[2]=-100; I[3]=70 separates reset modes.
    clear_mem();
    off_mem[1] = 10'd2; off_mem[2] = 10'd1; off_mem[3] = 10'd1;
    w_mem[0] = 8'd127; idx_mem[0] = 10'd1;
    w_mem[1] = 8'd127; idx_mem[1] = 10'd1;
    w_mem[2] = 8'hFB;  idx_mem[2] = 10'd2;
    w_mem[3] = 8'd7;   idx_mem[3] = 10'd3;
    act_mem[1] = 8'd255; act_mem[2] = 8'd20; act_mem[3] = 8'd10;
    exp0.push_back(ev(1, 0));
    exp0.push_back(ev(1, 1)); exp0.push_back(ev(3, 1));
    exp0.push_back(ev(1, 2)); exp0.push_back(ev(3, 2));
    exp0.push_back(ev(1, 3));
    exp1.push_back(ev(1, 0));
    exp1.push_back(ev(1, 1)); exp1.push_back(ev(3, 1));
    exp1.push_back(ev(1, 2));
    exp1.push_back(ev(1, 3)); exp1.push_back(ev(3, 3));
    pulse_start(1'b1, 1'b1);
    wait_frame(1'b1, cyc);
    repeat (3) @(negedge clk);
    check("sat_drained0", exp0.size(), 0);
    check("sat_drained1", exp1.size(), 0);

    // Backpressure: 16 spikes into a 4-deep FIFO with the consumer stalled.
    clear_mem();
    for (int i = 0; i < N; i++) begin
      off_mem[i] = 10'd1; w_mem[i] = 8'd127; idx_mem[i] = 10'd1;
    end
    act_mem[1] = 8'd255;
    for (int s = 0; s < T; s++)
      for (int n = 0; n < N; n++) exp0.push_back(ev(n, s));
    ready0 = 1'b0;
    pulse_start(1'b1, 1'b0);
    repeat (150) @(negedge clk);
    check("bp_stalled_busy", busy0, 1);
    check("bp_valid", sv0, 1);
    check("bp_head", {aer0, step0}, ev(0, 0));
    ready0 = 1'b1;
    wait_frame(1'b0, cyc);
    repeat (3) @(negedge clk);
    check("bp_drained", exp0.size(), 0);

    // Reset during MAC, then a clean rerun.
    load_a();
    pulse_start(1'b1, 1'b0);
    repeat (6) @(negedge clk);
    check("mid_busy", busy0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_valid", sv0, 0);
    check("mid_rst_csr", csr_addr0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    exp0.push_back(ev(0, 1)); exp0.push_back(ev(0, 3));
    pulse_start(1'b1, 1'b0);
    wait_frame(1'b0, cyc);
    repeat (3) @(negedge clk);
    check("rerun_drained", exp0.size(), 0);

    // start while busy is ignored: exactly one done.
    d = done_cnt0;
    exp0.push_back(ev(0, 1)); exp0.push_back(ev(0, 3));
    pulse_start(1'b1, 1'b0);
    repeat (10) @(negedge clk);
    pulse_start(1'b1, 1'b0);
    wait_frame(1'b0, cyc);
    repeat (40) @(negedge clk);
    check("one_done", done_cnt0 - d, 1);
    check("idle_after", busy0, 0);
    check("ign_drained", exp0.size(), 0);
    check("final_q1", exp1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
